spi_slave: RTL and testbench

//  SPI mode-0 responder, MSB first: the far end of the radio-link SPI master.

---
 rtl/spi_slave_pkg.sv | 18 +
 rtl/spi_slave_in_sync.sv | 36 +++
 rtl/spi_slave.sv | 176 +++++++++++++++++
 tb/tb_spi_slave.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and state encoding for the SPI mode-0 responder.
//   SPI_BYTE_W    : serial word width
//   BIT_CNT_W     : width of the in-byte bit counter
//   IDLE_FILL_DEF : default byte shifted out when the tx buffer is empty
package spi_pkg;

   localparam int unsigned SPI_BYTE_W = 8;
   localparam int unsigned BIT_CNT_W  = 3;

   localparam logic [SPI_BYTE_W-1:0] IDLE_FILL_DEF = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_slave_in_sync.sv
// Multi-flop synchroniser for an asynchronous input with edge detection.
//   clk, rst     : system clock, asynchronous active-low reset
//   d            : asynchronous input
//   q            : synchronised level
//   rise_c/fall_c: single-cycle edge strobes derived from q and its history flop
module spi_in_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   // Synchroniser chain plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= {SYNC_STAGES{RST_VAL}};
         hist <= RST_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         hist <= sync[SYNC_STAGES-1];
      end
   end

   assign q      = sync[SYNC_STAGES-1];
   assign rise_c = q & ~hist;
   assign fall_c = ~q & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampling ss/sck/mosi in the clk domain.
//   clk, rst    : system clock (>= 8x sck), asynchronous active-low reset
//   ss, sck,mosi: SPI bus inputs (asynchronous)
//   miso,miso_oe: serial data out (0 when deselected) and pad enable
//   tx_data/tx_load/tx_ready : one-deep transmit buffer interface
//   rx_data/rx_valid         : last received byte and its update strobe
//   busy, tx_underrun, frame_abort : status and event pulses
// Optional feature macro SPI_SLAVE_CHIP_RDY_EN adds chip_rdy_n, which holds
// miso high and ignores sck before the first sck rise of a frame.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned            SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0]  IDLE_FILL   = IDLE_FILL_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ss,
   input  logic                  sck,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  frame_abort
`ifdef SPI_SLAVE_CHIP_RDY_EN
   ,
   input  logic                  chip_rdy_n
`endif
);

   spi_state_e               state;
   logic [BIT_CNT_W-1:0]     bit_cnt;
   logic                     started;
   logic [SPI_BYTE_W-1:0]    tx_sh;
   logic [SPI_BYTE_W-2:0]    rx_sh;
   logic [SPI_BYTE_W-1:0]    tx_buf;
   logic [SYNC_STAGES-1:0]   mosi_sync;

   logic ss_s, ss_rise_c, ss_fall_c;
   logic sck_s, sck_rise_c, sck_fall_c;
   logic mosi_s;
   logic hold_c, rise_ok_c, reload_c, underrun_c;
   logic [SPI_BYTE_W-1:0] reload_byte_c;

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk(clk), .rst(rst), .d(ss), .q(ss_s), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
   );

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
   );

   // mosi needs the same latency as sck, but no edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mosi_sync <= '0;
      else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Ready-handshake window: only before the frame's first accepted sck rise
`ifdef SPI_SLAVE_CHIP_RDY_EN
   assign hold_c = ~started & (bit_cnt == '0) & chip_rdy_n;
`else
   assign hold_c = 1'b0;
`endif

   // Reload decision and the byte that the reload would take
   always_comb begin
      rise_ok_c     = sck_rise_c & ~hold_c;
      reload_c      = 1'b0;
      reload_byte_c = IDLE_FILL;
      underrun_c    = 1'b0;
      case (state)
         ST_LOAD:  reload_c = ~ss_s;
         ST_SHIFT: reload_c = ~ss_rise_c & ~rise_ok_c & sck_fall_c & started & (bit_cnt == '0);
         default:  reload_c = 1'b0;
      endcase
      if (!tx_ready)    reload_byte_c = tx_buf;
      else if (tx_load) reload_byte_c = tx_data;
      else              underrun_c    = 1'b1;
   end

   // Transmit buffer: a reload frees it in the same cycle a new byte may land
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_buf   <= '0;
         tx_ready <= 1'b1;
      end else if (reload_c) begin
         if (!tx_ready && tx_load) tx_buf <= tx_data;
         else                      tx_ready <= 1'b1;
      end else if (tx_load && tx_ready) begin
         tx_buf   <= tx_data;
         tx_ready <= 1'b0;
      end
   end

   // Frame FSM with shifters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         started     <= 1'b0;
         tx_sh       <= '0;
         rx_sh       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         busy        <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
         miso_oe     <= ~ss_s;
         busy        <= ~ss_s;
         case (state)
            ST_IDLE: begin
               miso    <= 1'b0;
               bit_cnt <= '0;
               started <= 1'b0;
               if (ss_fall_c) state <= ST_LOAD;
            end
            ST_LOAD: begin
               bit_cnt <= '0;
               started <= 1'b0;
               if (ss_s) begin
                  miso  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  tx_sh       <= reload_byte_c;
                  tx_underrun <= underrun_c;
                  miso        <= hold_c | reload_byte_c[SPI_BYTE_W-1];
                  state       <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (ss_rise_c) begin
                  // Partial byte and pending shifter content are discarded
                  frame_abort <= (bit_cnt != '0);
                  bit_cnt     <= '0;
                  started     <= 1'b0;
                  miso        <= 1'b0;
                  state       <= ST_IDLE;
               end else if (rise_ok_c) begin
                  rx_sh   <= {rx_sh[SPI_BYTE_W-3:0], mosi_s};
                  bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                  started <= 1'b1;
                  if (bit_cnt == '1) begin
                     rx_data  <= {rx_sh, mosi_s};
                     rx_valid <= 1'b1;
                  end
               end else if (reload_c) begin
                  tx_sh       <= reload_byte_c;
                  tx_underrun <= underrun_c;
                  miso        <= reload_byte_c[SPI_BYTE_W-1];
               end else if (sck_fall_c && started) begin
                  tx_sh <= tx_sh << 1;
                  miso  <= tx_sh[SPI_BYTE_W-2];
               end else begin
                  miso <= hold_c | tx_sh[SPI_BYTE_W-1];
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bus-level SPI master drives frames at
// clk/8 and a transaction-level model predicts miso bytes, rx bytes, underrun
// and abort counts from the buffer/reload rules.
module tb_spi_slave;

   localparam int unsigned HALF = 4;

   logic       clk = 1'b0;
   logic       rst, ss, sck, mosi, tx_load;
   logic [7:0] tx_data;
   logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
   logic [7:0] rx_data;
`ifdef SPI_SLAVE_CHIP_RDY_EN
   logic       chip_rdy_n;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Observed event counts
   int         n_valid = 0, n_under = 0, n_abort = 0;
   logic [7:0] rx_q[$];

   // Model state
   logic [7:0] mbuf[$];
   int         exp_under = 0;
   int         exp_abort = 0;
   logic [7:0] cur_tx;

   spi_slave dut (
      .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .tx_underrun(tx_underrun), .frame_abort(frame_abort)
`ifdef SPI_SLAVE_CHIP_RDY_EN
      , .chip_rdy_n(chip_rdy_n)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         if (rx_valid) begin
            n_valid++;
            rx_q.push_back(rx_data);
         end
         if (tx_underrun) n_under++;
         if (frame_abort) n_abort++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: a reload takes the buffered byte, else the idle fill with an underrun
   task automatic model_reload(output logic [7:0] b);
      if (mbuf.size() > 0) b = mbuf.pop_front();
      else begin
         b = 8'h00;
         exp_under++;
      end
   endtask

   task automatic load_byte(input logic [7:0] b);
      @(negedge clk);
      tests_run++;
      if (tx_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_ready: tx_ready=%b want 1", tx_ready);
      end
      tx_data = b;
      tx_load = 1'b1;
      mbuf.push_back(b);
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   // Shift nb bits MSB first; optionally load the tx buffer mid-byte
   task automatic spi_bits(input logic [7:0] mo, input int nb, input bit do_ld,
                           input logic [7:0] ld, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i >= 8 - nb; i--) begin
         mosi = mo[i];
         for (int k = 0; k < int'(HALF); k++) begin
            @(negedge clk);
            if (do_ld && i == 4 && k == 0) begin
               tests_run++;
               if (tx_ready !== 1'b1) begin
                  tests_failed++;
                  $display("FAIL midbyte_ready: tx_ready=%b want 1", tx_ready);
               end
               tx_data = ld;
               tx_load = 1'b1;
               mbuf.push_back(ld);
            end else begin
               tx_load = 1'b0;
            end
         end
         mi[i] = miso;
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic frame_begin();
      ss = 1'b0;
      wait_clk(8);
      model_reload(cur_tx);
      tests_run++;
      if ({busy, miso_oe} !== 2'b11) begin
         tests_failed++;
         $display("FAIL selected_flags: busy,miso_oe=%b want 11", {busy, miso_oe});
      end
   endtask

   task automatic frame_end(input string name);
      wait_clk(8);
      ss = 1'b1;
      wait_clk(8);
      tests_run++;
      if ({miso, miso_oe, busy} !== 3'b000) begin
         tests_failed++;
         $display("FAIL %s_deselect: miso,oe,busy=%b want 000", name, {miso, miso_oe, busy});
      end
   endtask

   // One full byte with checks on miso and the received byte
   task automatic xfer(input logic [7:0] mo, input bit do_ld, input logic [7:0] ld,
                       input string name);
      logic [7:0] mi, exp_mi, got;
      int v0;
      exp_mi = cur_tx;
      v0 = n_valid;
      spi_bits(mo, 8, do_ld, ld, mi);
      wait_clk(6);
      model_reload(cur_tx);
      tests_run++;
      if (mi !== exp_mi) begin
         tests_failed++;
         $display("FAIL %s_miso: got %h want %h", name, mi, exp_mi);
      end
      tests_run++;
      if (n_valid != v0 + 1) begin
         tests_failed++;
         $display("FAIL %s_rxvalid: pulses %0d want 1", name, n_valid - v0);
      end else begin
         got = rx_q.pop_front();
         if (got !== mo) begin
            tests_failed++;
            $display("FAIL %s_rxdata: got %h want %h", name, got, mo);
         end
      end
   endtask

   task automatic check_counts(input string name);
      tests_run++;
      if (n_under != exp_under || n_abort != exp_abort) begin
         tests_failed++;
         $display("FAIL %s_events: underrun %0d want %0d, abort %0d want %0d",
                  name, n_under, exp_under, n_abort, exp_abort);
      end
   endtask

   task automatic check_reset_vals(input string name);
      tests_run++;
      if ({miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_abort} !== 7'b0010000
          || rx_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL %s: flags=%b want 0010000 rx_data=%h want 00", name,
                  {miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_abort}, rx_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
`ifdef SPI_SLAVE_CHIP_RDY_EN
      chip_rdy_n = 1'b0;
`endif
      wait_clk(3);
      check_reset_vals("reset");
      rst = 1'b1;
      wait_clk(4);
   endtask

   task automatic test_basic();
      load_byte(8'hA5);
      frame_begin();
      xfer(8'h3C, 1'b0, 8'h00, "basic");
      frame_end("basic");
      check_counts("basic");
   endtask

   task automatic test_back_to_back();
      load_byte(8'h12);
      frame_begin();
      xfer(8'($urandom), 1'b1, 8'h34, "b2b0");
      xfer(8'($urandom), 1'b0, 8'h00, "b2b1");
      frame_end("b2b");
      check_counts("b2b");
   endtask

   task automatic test_underrun();
      frame_begin();
      xfer(8'($urandom), 1'b0, 8'h00, "under0");
      xfer(8'($urandom), 1'b0, 8'h00, "under1");
      frame_end("under");
      check_counts("under");
   endtask

   task automatic test_abort();
      logic [7:0] mi;
      int v0;
      load_byte(8'hC3);
      frame_begin();
      v0 = n_valid;
      spi_bits(8'($urandom), 5, 1'b1, 8'h69, mi);
      wait_clk(6);
      ss = 1'b1;
      exp_abort++;
      wait_clk(8);
      tests_run++;
      if (n_valid != v0 || miso !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_state: rx_valid pulses %0d want 0, miso=%b want 0", n_valid - v0, miso);
      end
      check_counts("abort");
      frame_begin();
      xfer(8'($urandom), 1'b0, 8'h00, "post_abort");
      frame_end("post_abort");
      check_counts("post_abort");
   endtask

   task automatic test_async_reset();
      logic [7:0] mi;
      load_byte(8'($urandom));
      frame_begin();
      spi_bits(8'($urandom), 3, 1'b0, 8'h00, mi);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_vals("async_reset");
      mbuf.delete();
      ss = 1'b1;
      wait_clk(3);
      rst = 1'b1;
      wait_clk(8);
      load_byte(8'($urandom));
      frame_begin();
      xfer(8'($urandom), 1'b0, 8'h00, "post_reset");
      frame_end("post_reset");
      check_counts("post_reset");
   endtask

   task automatic test_random();
      for (int f = 0; f < 6; f++) begin
         int nbytes;
         nbytes = int'($urandom_range(1, 3));
         if (mbuf.size() == 0 && $urandom_range(0, 1) == 1) load_byte(8'($urandom));
         frame_begin();
         for (int b = 0; b < nbytes; b++)
            xfer(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), "rand");
         frame_end("rand");
      end
      check_counts("rand");
   endtask

`ifdef SPI_SLAVE_CHIP_RDY_EN
   task automatic test_chip_rdy();
      logic [7:0] exp_first;
      load_byte(8'h5A);
      chip_rdy_n = 1'b1;
      frame_begin();
      for (int p = 0; p < 2; p++) begin
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
         wait_clk(HALF);
         tests_run++;
         if (miso !== 1'b1) begin
            tests_failed++;
            $display("FAIL chip_rdy_hold: miso=%b want 1", miso);
         end
      end
      wait_clk(4);
      chip_rdy_n = 1'b0;
      wait_clk(4);
      exp_first = cur_tx;
      tests_run++;
      if (miso !== exp_first[7]) begin
         tests_failed++;
         $display("FAIL chip_rdy_release: miso=%b want %b", miso, exp_first[7]);
      end
      xfer(8'($urandom), 1'b0, 8'h00, "chip_rdy");
      frame_end("chip_rdy");
      check_counts("chip_rdy");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_async_reset();
      test_random();
`ifdef SPI_SLAVE_CHIP_RDY_EN
      test_chip_rdy();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
